// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level helpers.
// Used by the SubBytes / MixColumns family of stages.
package aes_pkg;

  // 4x4 state, byte [r][c]
  typedef logic [3:0][3:0][7:0] state_t;

  localparam logic [7:0] AES_REDUCE   = 8'h1B;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;
  localparam logic [7:0] FWD_AFFINE_C = 8'h63;

  typedef enum logic [1:0] {
    ISB_IDLE    = 2'd0,
    ISB_COMPUTE = 2'd1,
    ISB_DONE    = 2'd2
  } isb_state_e;

  // inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
  function automatic logic [7:0] invaff(
    input logic [7:0] s
  );
    return {s[6:0], s[7]}
         ^ {s[4:0], s[7:5]}
         ^ {s[1:0], s[7:2]}
         ^ INV_AFFINE_C;
  endfunction

  // forward affine: s ^ rotl1..rotl4 ^ 0x63
  function automatic logic [7:0] fwdaff(
    input logic [7:0] s
  );
    return s
         ^ {s[6:0], s[7]}
         ^ {s[5:0], s[7:6]}
         ^ {s[4:0], s[7:5]}
         ^ {s[3:0], s[7:4]}
         ^ FWD_AFFINE_C;
  endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiply, reduced mod 0x11B.
// Ports: a, b operands; p = a*b.
module gf256_mul
  import aes_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] t;

  // shift-and-add with xtime reduction per bit
  always_comb begin
    p = '0;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      if (t[7]) t = {t[6:0], 1'b0} ^ AES_REDUCE;
      else      t = {t[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: invaff then x^254 per byte.
// Ports: clk, reset (sync high), in_valid/in_ready/in_state,
//   out_valid/out_ready/out_state, busy (high in COMPUTE).
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in_state,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out_state,
  output logic   busy
);

  localparam int PASSES = 16 / LANES;
  localparam int PW =
    (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PW-1:0] LAST =
    PW'(PASSES - 1);

  isb_state_e    st;
  logic [PW-1:0] pass;
  logic [2:0]    step;

  // flat byte i = c*4 + r
  logic [7:0] b   [16];
  logic [7:0] res [16];

  logic [7:0] sq     [LANES];
  logic [7:0] acc    [LANES];
  logic [3:0] idx    [LANES];
  logic [7:0] sq_in  [LANES];
  logic [7:0] acc_in [LANES];
  logic [7:0] sq2    [LANES];
  logic [7:0] prod   [LANES];

  assign in_ready  = (st == ISB_IDLE);
  assign busy      = (st == ISB_COMPUTE);
  assign out_valid = (st == ISB_DONE);

  // step 0 seeds from b and 1 directly, so
  // seven steps give b^(2+4+...+128) = b^254
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      idx[l] = 4'(int'(pass) * LANES + l);
      if (step == 3'd0) begin
        sq_in[l]  = b[idx[l]];
        acc_in[l] = 8'h01;
      end else begin
        sq_in[l]  = sq[l];
        acc_in[l] = acc[l];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gf256_mul u_sq (
      .a (sq_in[l]),
      .b (sq_in[l]),
      .p (sq2[l])
    );
    gf256_mul u_mul (
      .a (acc_in[l]),
      .b (sq2[l]),
      .p (prod[l])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= ISB_IDLE;
      pass <= '0;
      step <= '0;
      for (int i = 0; i < 16; i++) begin
        b[i]   <= '0;
        res[i] <= '0;
      end
      for (int l = 0; l < LANES; l++) begin
        sq[l]  <= '0;
        acc[l] <= '0;
      end
    end else begin
      unique case (st)
        ISB_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++)
              b[i] <= invaff(in_state[i % 4][i / 4]);
            pass <= '0;
            step <= '0;
            st   <= ISB_COMPUTE;
          end
        end
        ISB_COMPUTE: begin
          for (int l = 0; l < LANES; l++) begin
            sq[l]  <= sq2[l];
            acc[l] <= prod[l];
          end
          if (step == 3'd6) begin
            for (int l = 0; l < LANES; l++)
              res[idx[l]] <= prod[l];
            step <= '0;
            if (pass == LAST) st <= ISB_DONE;
            else pass <= pass + 1'b1;
          end else begin
            step <= step + 3'd1;
          end
        end
        ISB_DONE: begin
          if (out_ready) st <= ISB_IDLE;
        end
        default: st <= ISB_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_out
    assign out_state[i % 4][i / 4] = res[i];
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter across LANES 16, 2, 4, 1.
// Directed vectors plus S-box round trips.
module tb_inv_sub_bytes_iter;
  import aes_pkg::*;

  localparam int NI = 4;
  localparam int LN [NI] = '{16, 2, 4, 1};

  logic   clk;
  logic   rst       [NI];
  logic   in_valid  [NI];
  logic   in_ready  [NI];
  logic   out_valid [NI];
  logic   out_ready [NI];
  logic   busy      [NI];
  state_t in_state  [NI];
  state_t out_state [NI];

  int total;
  int bad;

  logic [7:0] fsb [256];
  logic [7:0] isb [256];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    inv_sub_bytes_iter #(.LANES(LN[g])) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gm(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p, a, m;
    p = 0; a = x; m = y;
    for (int k = 0; k < 8; k++) begin
      if (m[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      m = m >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(
    input logic [7:0] x
  );
    for (int y = 1; y < 256; y++)
      if (gm(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic state_t fwd_st(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = fsb[s[r][c]];
    return o;
  endfunction

  function automatic state_t inv_st(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = isb[s[r][c]];
    return o;
  endfunction

  function automatic state_t rnd_st();
    return {$urandom(), $urandom(),
            $urandom(), $urandom()};
  endfunction

  // out_valid is expected 7*passes edges after
  // the accepting edge, i.e. cycle T+1+7*passes
  task automatic run(
    input  int     k,
    input  state_t s,
    output state_t r
  );
    int n;
    n = 0;
    in_state[k] = s;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid[k] = 1'b0;
    chk($sformatf("busy%0d", k), busy[k], 1);
    n = 0;
    while (!out_valid[k] && n < 300) begin
      tick();
      n++;
    end
    chk($sformatf("lat%0d", k), n,
        7 * (16 / LN[k]));
    r = out_state[k];
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    chk($sformatf("idle%0d", k),
        {out_valid[k], in_ready[k]}, 2'b01);
  endtask

  state_t t2_in, t2_ex, s, r, e;
  state_t vq [5];
  time    acc_t [5];
  state_t got [$];

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < NI; k++) begin
      rst[k]       = 1'b1;
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      in_state[k]  = '0;
    end
    for (int x = 0; x < 256; x++)
      fsb[x] = fwdaff(ginv(8'(x)));
    for (int x = 0; x < 256; x++)
      isb[fsb[x]] = 8'(x);

    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst%0d", k),
          {in_ready[k], out_valid[k], busy[k]},
          3'b100);
      chk($sformatf("rst_out%0d", k),
          out_state[k], '0);
      rst[k] = 1'b0;
    end
    tick();

    // all 0x63 -> all zero
    s = {16{8'h63}};
    run(0, s, r);
    chk("all63", r, '0);

    // known InvSbox entries
    t2_in = {16{8'h63}};
    t2_ex = '0;
    t2_in[0][0] = 8'h00; t2_ex[0][0] = 8'h52;
    t2_in[1][0] = 8'h7C; t2_ex[1][0] = 8'h01;
    t2_in[2][0] = 8'hED; t2_ex[2][0] = 8'h53;
    t2_in[3][0] = 8'h16; t2_ex[3][0] = 8'hFF;
    t2_in[0][1] = 8'h76; t2_ex[0][1] = 8'h0F;
    t2_in[1][1] = 8'hFE; t2_ex[1][1] = 8'h0C;
    t2_in[2][1] = 8'h30; t2_ex[2][1] = 8'h08;
    t2_in[3][1] = 8'h01; t2_ex[3][1] = 8'h09;
    for (int k = 0; k < NI; k++) begin
      run(k, t2_in, r);
      chk($sformatf("vec%0d", k), r, t2_ex);
    end

    // round trips through forward SubBytes
    for (int j = 0; j < 100; j++) begin
      s = rnd_st();
      run(2, fwd_st(s), r);
      chk("rt4", r, s);
    end
    for (int j = 0; j < 50; j++) begin
      s = rnd_st();
      run(3, fwd_st(s), r);
      chk("rt1", r, s);
    end

    // backpressure in DONE
    s = rnd_st();
    e = inv_st(s);
    in_state[0] = s;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int n = 0; n < 50; n++)
      if (!out_valid[0]) tick();
    for (int n = 0; n < 20; n++) begin
      chk("hold_v", out_valid[0], 1);
      chk("hold_rdy", in_ready[0], 0);
      chk("hold_st", out_state[0], e);
      in_valid[0] = n[0];
      in_state[0] = rnd_st();
      tick();
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("rel", {out_valid[0], in_ready[0]}, 2'b01);
    tick();
    tick();
    chk("rel_idle", {out_valid[0], busy[0]}, 2'b00);
    chk("rel_st", out_state[0], e);

    // reset during pass 3 (LANES=2)
    in_state[1] = rnd_st();
    in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    for (int n = 0; n < 22; n++) tick();
    chk("mid_busy", {busy[1], out_valid[1]}, 2'b10);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("abort",
        {in_ready[1], out_valid[1], busy[1]},
        3'b100);
    chk("abort_st", out_state[1], '0);
    run(1, t2_in, r);
    chk("after_abort", r, t2_ex);

    // back-to-back with out_ready high
    for (int j = 0; j < 5; j++) vq[j] = rnd_st();
    out_ready[0] = 1'b1;
    fork
      begin
        for (int j = 0; j < 5; j++) begin
          int n;
          n = 0;
          in_state[0] = vq[j];
          in_valid[0] = 1'b1;
          while (!in_ready[0] && n < 50) begin
            tick();
            n++;
          end
          @(posedge clk);
          acc_t[j] = $time;
          #1;
        end
        in_valid[0] = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (got.size() < 5 && n < 200) begin
          if (out_valid[0]) got.push_back(out_state[0]);
          tick();
          n++;
        end
      end
    join
    out_ready[0] = 1'b0;
    chk("b2b_n", got.size(), 5);
    for (int j = 1; j < 5; j++)
      chk($sformatf("b2b_gap%0d", j),
          acc_t[j] - acc_t[j-1], 90);
    for (int j = 0; j < 5; j++)
      chk($sformatf("b2b%0d", j),
          (j < got.size()) ? got[j] : '0,
          inv_st(vq[j]));

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
